// File: rtl/bit32_regfile_pkg.sv
// bit32_regfile_pkg: shared constants and trap state encoding for the register file
package bit32_regfile_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 2;
  typedef enum logic {
    IDLE    = 1'b0,
    TRAPPED = 1'b1
  } trap_state_t;
endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: read-port select between zero, write-through data and stored data
module regfile_bypass_mux
  import bit32_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic                  wr_ok,
  input  logic [WIDTH-1:0]      stored,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      data
);
  always_comb begin
    data = (rd_addr == DEPTH_LOG2'(REG_ZERO)) ? '0 : (wr_ok && rd_addr == wr_addr) ? wr_data : stored;
  end
endmodule

// File: rtl/bit32_regfile.sv
// bit32_regfile: 32x32 ALU register file with write-through reads, flag register and sticky overflow trap
module bit32_regfile
  import bit32_regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] ra_addr,
  input  logic [DEPTH_LOG2-1:0] rb_addr,
  output logic [WIDTH-1:0]      ra_data,
  output logic [WIDTH-1:0]      rb_data,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  flag_we,
  input  logic                  z_in,
  input  logic                  v_in,
  input  logic                  c_in,
  input  logic                  trap_en,
  input  logic                  trap_clr,
  output logic [2:0]            flags,
  output logic                  trap,
  output logic [DEPTH_LOG2-1:0] trap_addr
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  trap_state_t state, state_nx;
  logic trap_hit, wr_ok;
  always_comb begin
    trap_hit = flag_we & v_in & trap_en;
    wr_ok    = we & (wr_addr != DEPTH_LOG2'(REG_ZERO)) & (state == IDLE) & ~trap_hit;
    state_nx = trap_hit ? TRAPPED : (trap_clr ? IDLE : state);
    trap     = (state == TRAPPED);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flags     <= '0;
      trap_addr <= '0;
    end else begin
      state <= state_nx;
      if (flag_we) begin
        flags[FLAG_Z] <= z_in;
        flags[FLAG_V] <= v_in;
        flags[FLAG_C] <= c_in;
      end
      if (trap_hit && (state == IDLE || trap_clr)) trap_addr <= wr_addr;
    end
  end
  regfile_bypass_mux #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mux_a (
    .rd_addr(ra_addr),
    .wr_addr(wr_addr),
    .wr_ok  (wr_ok),
    .stored (mem[ra_addr]),
    .wr_data(wr_data),
    .data   (ra_data)
  );
  regfile_bypass_mux #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mux_b (
    .rd_addr(rb_addr),
    .wr_addr(wr_addr),
    .wr_ok  (wr_ok),
    .stored (mem[rb_addr]),
    .wr_data(wr_data),
    .data   (rb_data)
  );
endmodule

// File: tb/tb_bit32_regfile.sv
// tb_bit32_regfile: directed scoreboard bench for bit32_regfile
module tb_bit32_regfile;
  logic        clk = 0;
  logic        reset = 1;
  logic [4:0]  ra_addr = 0, rb_addr = 0, wr_addr = 0;
  logic [31:0] ra_data, rb_data, wr_data = 0;
  logic        we = 0, flag_we = 0, z_in = 0, v_in = 0, c_in = 0, trap_en = 0, trap_clr = 0;
  logic [2:0]  flags;
  logic        trap;
  logic [4:0]  trap_addr;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int          k;
    logic [31:0] v;
    string       nm;
  } exp_t;
  exp_t sb[$];
  bit32_regfile dut (
    .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .z_in(z_in), .v_in(v_in),
    .c_in(c_in), .trap_en(trap_en), .trap_clr(trap_clr), .flags(flags),
    .trap(trap), .trap_addr(trap_addr)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] actual(int k);
    case (k)
      0:       return ra_data;
      1:       return rb_data;
      2:       return {29'd0, flags};
      3:       return {31'd0, trap};
      default: return {27'd0, trap_addr};
    endcase
  endfunction
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.k);
      n_chk++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
  end
  task automatic expect_v(int k, logic [31:0] v, string nm);
    exp_t e;
    e.k = k; e.v = v; e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    go();
    reset = 0; we = 1; wr_addr = 5; wr_data = 32'h5555_5555;
    flag_we = 1; {c_in, v_in, z_in} = 3'b101; ra_addr = 5;
    expect_v(0, 32'h5555_5555, "pre_bypass");
    go();
    we = 0; {c_in, v_in, z_in} = 3'b010; trap_en = 1; wr_addr = 4;
    expect_v(2, 32'd5, "pre_flags");
    expect_v(0, 32'h5555_5555, "pre_stored");
    go();
    flag_we = 0; trap_en = 0; {c_in, v_in, z_in} = 3'b000;
    expect_v(3, 32'd1, "pre_trap");
    expect_v(4, 32'd4, "pre_trap_addr");
    expect_v(2, 32'd2, "pre_flags2");
    go();
    #2 reset = 1;
    expect_v(0, 32'd0, "rst_async_ra");
    expect_v(2, 32'd0, "rst_async_flags");
    expect_v(3, 32'd0, "rst_async_trap");
    expect_v(4, 32'd0, "rst_async_trap_addr");
    for (int i = 0; i < 32; i++) begin
      go();
      ra_addr = 5'(i); rb_addr = 5'(31 - i);
      expect_v(0, 32'd0, "rst_ra");
      expect_v(1, 32'd0, "rst_rb");
    end
    go();
    reset = 0; we = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; ra_addr = 0; rb_addr = 0;
    go();
    wr_addr = 0; wr_data = 32'h1; ra_addr = 5; rb_addr = 5;
    expect_v(0, 32'hDEAD_BEEF, "wr5_ra");
    expect_v(1, 32'hDEAD_BEEF, "wr5_rb");
    go();
    we = 0; ra_addr = 0; rb_addr = 0;
    expect_v(0, 32'd0, "r0_ra");
    expect_v(1, 32'd0, "r0_rb");
    go();
    we = 1; wr_addr = 7; wr_data = 32'h1234_5678; ra_addr = 7; rb_addr = 5;
    expect_v(0, 32'h1234_5678, "byp_ra7");
    expect_v(1, 32'hDEAD_BEEF, "byp_rb_other");
    go();
    wr_addr = 0; wr_data = 32'hCAFE_F00D; ra_addr = 0; rb_addr = 7;
    expect_v(0, 32'd0, "byp_r0");
    expect_v(1, 32'h1234_5678, "stored7");
    go();
    wr_addr = 10; wr_data = 32'hA5A5_0F0F; ra_addr = 10; rb_addr = 10;
    expect_v(0, 32'hA5A5_0F0F, "byp_both_ra");
    expect_v(1, 32'hA5A5_0F0F, "byp_both_rb");
    go();
    we = 0; flag_we = 1; {c_in, v_in, z_in} = 3'b101;
    expect_v(0, 32'hA5A5_0F0F, "stored10");
    go();
    flag_we = 0; {c_in, v_in, z_in} = 3'b010;
    expect_v(2, 32'd5, "flags_101");
    go();
    {c_in, v_in, z_in} = 3'b011;
    expect_v(2, 32'd5, "flags_hold");
    expect_v(3, 32'd0, "no_trap");
    go();
    trap_en = 1; flag_we = 1; {c_in, v_in, z_in} = 3'b010;
    we = 1; wr_addr = 9; wr_data = 32'h0000_FFFF; ra_addr = 9;
    expect_v(0, 32'd0, "trap_edge_no_byp");
    go();
    trap_en = 0; flag_we = 0; v_in = 0; wr_addr = 3; wr_data = 32'h3333_3333; rb_addr = 3;
    expect_v(3, 32'd1, "trap_set");
    expect_v(4, 32'd9, "trap_addr9");
    expect_v(0, 32'd0, "reg9_kept");
    expect_v(2, 32'd2, "trap_flags");
    expect_v(1, 32'd0, "trapped_no_byp");
    go();
    we = 0; trap_clr = 1; flag_we = 1; {c_in, v_in, z_in} = 3'b101; ra_addr = 3;
    expect_v(0, 32'd0, "reg3_suppressed");
    expect_v(3, 32'd1, "trap_sticky");
    go();
    trap_clr = 0; flag_we = 0; we = 1; wr_addr = 3; wr_data = 32'h3333_3333;
    expect_v(3, 32'd0, "trap_cleared");
    expect_v(2, 32'd5, "flags_while_trapped");
    expect_v(0, 32'h3333_3333, "byp_after_clr");
    go();
    we = 0; trap_en = 1; flag_we = 1; {c_in, v_in, z_in} = 3'b010; wr_addr = 11;
    expect_v(0, 32'h3333_3333, "reg3_landed");
    go();
    trap_clr = 1; wr_addr = 12; we = 1; wr_data = 32'h0000_1212; ra_addr = 12;
    expect_v(3, 32'd1, "trap2_set");
    expect_v(4, 32'd11, "trap_addr11");
    expect_v(0, 32'd0, "coll_no_byp");
    go();
    trap_clr = 0; flag_we = 0; trap_en = 0; v_in = 0; we = 0;
    expect_v(3, 32'd1, "coll_trap");
    expect_v(4, 32'd12, "coll_trap_addr");
    expect_v(0, 32'd0, "coll_reg12");
    go();
    trap_clr = 1;
    go();
    trap_clr = 0;
    expect_v(3, 32'd0, "coll_cleared");
    go();
    we = 1; wr_addr = 20; wr_data = 32'h2020_2020; ra_addr = 20;
    #2 reset = 1;
    go();
    reset = 0; we = 0;
    expect_v(0, 32'd0, "rst_lost_write");
    go();
    go();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
